// File: rtl/vec_sweep_engine.sv
// Exhaustive stimulus sweeper: drives all 2^WIDTH vectors (HOLD cycles each), counts resp=1 samples.
// Optional MISR signature output enabled by macro SWEEP_MISR_EN.
module vec_sweep_engine #(
  parameter int WIDTH = 4,
  parameter int HOLD  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             resp,
  output logic [WIDTH-1:0] vec,
  output logic             sel,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH:0]   ones_cnt
`ifdef SWEEP_MISR_EN
  ,
  output logic [15:0]      sig
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  localparam logic [7:0]       HOLD_LAST = 8'(HOLD - 1);
  localparam logic [WIDTH-1:0] VEC_LAST  = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_vec;
  logic             r_sel;
  logic             r_aborted;
  logic [7:0]       r_hold;
  logic [WIDTH:0]   r_ones;
  logic             w_accept;
  logic             w_abort_run;
  logic             w_sample;
  logic             w_hold_end;
  logic             w_last;

  assign w_hold_end = (r_hold == HOLD_LAST);
  assign w_last     = (r_vec == VEC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_abort_run = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // abort suppresses the sample taken on the same cycle
        if (abort) begin
          w_abort_run = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_hold_end) begin
          w_sample = 1'b1;
          if (w_last) begin
            w_state_nxt = S_FINISH;
          end
        end
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec     <= '0;
      r_sel     <= 1'b0;
      r_hold    <= '0;
      r_ones    <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= w_abort_run;
      if (w_accept) begin
        r_vec  <= '0;
        r_sel  <= 1'b1;
        r_hold <= '0;
        r_ones <= '0;
      end else if (r_state == S_RUN) begin
        if (w_abort_run || (w_sample && w_last)) begin
          r_vec  <= '0;
          r_sel  <= 1'b0;
          r_hold <= '0;
        end else begin
          r_sel <= ~r_sel;
          if (w_sample) begin
            r_vec  <= r_vec + WIDTH'(1);
            r_hold <= '0;
          end else begin
            r_hold <= r_hold + 8'd1;
          end
        end
        if (w_sample && resp) begin
          r_ones <= r_ones + (WIDTH+1)'(1);
        end
      end else begin
        r_vec  <= '0;
        r_sel  <= 1'b0;
        r_hold <= '0;
      end
    end
  end

`ifdef SWEEP_MISR_EN
  logic [15:0] r_sig;

  // x^16 + x^12 + x^5 + 1, one response bit folded in per sampled vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= 16'hFFFF;
    end else if (w_accept) begin
      r_sig <= 16'hFFFF;
    end else if (w_sample) begin
      r_sig <= {r_sig[14:0], 1'b0} ^ ({16{r_sig[15]}} & 16'h1021) ^ {15'b0, resp};
    end
  end

  assign sig = r_sig;
`endif

  assign vec      = r_vec;
  assign sel      = r_sel;
  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_FINISH);
  assign aborted  = r_aborted;
  assign ones_cnt = r_ones;

endmodule

// File: tb/tb_vec_sweep_engine.sv
// Directed bench for vec_sweep_engine: one HOLD=1 and one HOLD=3 instance on a shared clock/reset.
module tb_vec_sweep_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start1 = 1'b0, abort1 = 1'b0, resp1;
  logic       start3 = 1'b0, abort3 = 1'b0, resp3;
  logic [3:0] vec1, vec3;
  logic       sel1, busy1, done1, aborted1;
  logic       sel3, busy3, done3, aborted3;
  logic [4:0] ones1, ones3;
  logic [1:0] mode1 = 2'd0;
  int         n_checks = 0;
  int         n_errors = 0;
`ifdef SWEEP_MISR_EN
  logic [15:0] sig1, sig3;
  logic [15:0] misr_ref;
`endif

  always #5 clk = ~clk;

  // mode1: 0 parity, 1 constant one, 2 constant zero
  assign resp1 = (mode1 == 2'd0) ? ^vec1 : (mode1 == 2'd1);
  assign resp3 = &vec3;

  vec_sweep_engine #(.WIDTH(4), .HOLD(1)) u_dut_h1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .resp(resp1),
    .vec(vec1), .sel(sel1), .busy(busy1), .done(done1), .aborted(aborted1),
    .ones_cnt(ones1)
`ifdef SWEEP_MISR_EN
    , .sig(sig1)
`endif
  );

  vec_sweep_engine #(.WIDTH(4), .HOLD(3)) u_dut_h3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .resp(resp3),
    .vec(vec3), .sel(sel3), .busy(busy3), .done(done3), .aborted(aborted3),
    .ones_cnt(ones3)
`ifdef SWEEP_MISR_EN
    , .sig(sig3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // returns at the falling edge of the first RUN cycle
  task automatic start_sweep(input bit use_h3);
    if (use_h3) start3 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

`ifdef SWEEP_MISR_EN
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic r);
    return {s[14:0], 1'b0} ^ ({16{s[15]}} & 16'h1021) ^ {15'b0, r};
  endfunction
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_vec", 32'(vec1), 0);
    check("rst_sel", 32'(sel1), 0);
    check("rst_busy", 32'(busy1), 0);
    check("rst_done", 32'(done1), 0);
    check("rst_aborted", 32'(aborted1), 0);
    check("rst_ones", 32'(ones1), 0);
`ifdef SWEEP_MISR_EN
    check("rst_sig", 32'(sig1), 32'hFFFF);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Sweep with parity response, HOLD=1
    mode1 = 2'd0;
    start_sweep(1'b0);
    for (int i = 0; i < 16; i++) begin
      check("t1_vec", 32'(vec1), i);
      check("t1_sel", 32'(sel1), ((i % 2) == 0) ? 1 : 0);
      check("t1_busy", 32'(busy1), 1);
      check("t1_done_low", 32'(done1), 0);
      @(negedge clk);
    end
    check("t1_done", 32'(done1), 1);
    check("t1_busy_fin", 32'(busy1), 0);
    check("t1_vec_fin", 32'(vec1), 0);
    check("t1_sel_fin", 32'(sel1), 0);
    check("t1_ones", 32'(ones1), 8);
`ifdef SWEEP_MISR_EN
    misr_ref = 16'hFFFF;
    for (int v = 0; v < 16; v++) begin
      logic [3:0] vv;
      vv = 4'(v);
      misr_ref = misr_step(misr_ref, ^vv);
    end
    check("t1_sig", 32'(sig1), 32'(misr_ref));
`endif
    start1 = 1'b1;  // start during FINISH must be ignored
    @(negedge clk);
    start1 = 1'b0;
    check("t1_fin_start_ign", 32'(busy1), 0);
    check("t1_done_pulse", 32'(done1), 0);
    check("t1_ones_hold", 32'(ones1), 8);
    @(negedge clk);
    check("t1_still_idle", 32'(busy1), 0);

`ifdef SWEEP_MISR_EN
    start_sweep(1'b0);
    repeat (16) @(negedge clk);
    check("t1_sig_repeat", 32'(sig1), 32'(misr_ref));
    @(negedge clk);
`endif

    // HOLD=3 with AND response
    start_sweep(1'b1);
    for (int i = 0; i < 48; i++) begin
      check("t2_vec", 32'(vec3), i / 3);
      check("t2_sel", 32'(sel3), ((i % 2) == 0) ? 1 : 0);
      check("t2_busy", 32'(busy3), 1);
      @(negedge clk);
    end
    check("t2_done", 32'(done3), 1);
    check("t2_ones", 32'(ones3), 1);
    @(negedge clk);

    // All ones: count reaches 16 without wrapping
    mode1 = 2'd1;
    start_sweep(1'b0);
    repeat (16) @(negedge clk);
    check("t3_done_all1", 32'(done1), 1);
    check("t3_ones_all1", 32'(ones1), 16);
    @(negedge clk);

    // All zeros; start together with abort in IDLE: start wins
    mode1 = 2'd2;
    abort1 = 1'b1;
    start_sweep(1'b0);
    abort1 = 1'b0;
    check("t3_start_wins", 32'(busy1), 1);
    check("t3_clear", 32'(ones1), 0);
    repeat (16) @(negedge clk);
    check("t3_done_all0", 32'(done1), 1);
    check("t3_ones_all0", 32'(ones1), 0);
    @(negedge clk);

    // Abort at vec=5
    mode1 = 2'd1;
    start_sweep(1'b0);
    repeat (5) @(negedge clk);
    check("t4_vec5", 32'(vec1), 5);
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    check("t4_aborted", 32'(aborted1), 1);
    check("t4_no_done", 32'(done1), 0);
    check("t4_busy", 32'(busy1), 0);
    check("t4_vec", 32'(vec1), 0);
    check("t4_sel", 32'(sel1), 0);
    check("t4_ones", 32'(ones1), 5);
    @(negedge clk);
    check("t4_aborted_pulse", 32'(aborted1), 0);
    check("t4_ones_hold", 32'(ones1), 5);
    abort1 = 1'b1;  // abort while idle does nothing
    @(negedge clk);
    abort1 = 1'b0;
    check("t4_idle_abort", 32'(aborted1), 0);
    check("t4_idle_ones", 32'(ones1), 5);

    // Reset mid-sweep at vec=9, then ignored restart during RUN
    mode1 = 2'd0;
    start_sweep(1'b0);
    repeat (9) @(negedge clk);
    check("t5_vec9", 32'(vec1), 9);
    check("t5_partial", 32'(ones1), 5);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_vec", 32'(vec1), 0);
    check("t5_rst_busy", 32'(busy1), 0);
    check("t5_rst_sel", 32'(sel1), 0);
    check("t5_rst_ones", 32'(ones1), 0);
    check("t5_rst_done", 32'(done1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_no_done", 32'(done1), 0);
    check("t5_no_abort", 32'(aborted1), 0);
    start_sweep(1'b0);
    repeat (3) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("t5_no_restart", 32'(vec1), 4);
    check("t5_busy", 32'(busy1), 1);
    repeat (12) @(negedge clk);
    check("t5_done", 32'(done1), 1);
    check("t5_ones", 32'(ones1), 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
